// File: rtl/alu_nibble_seq_pkg.sv
// Shared encodings for the nibble-serial ALU sequencer: FSM states, op codes and
// the nibble-counter width helper.
package alu_nibble_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Op[2]=0 selects the carry-chained arithmetic group, Op[2]=1 the logic group
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/alu_nibble_seq_alu.sv
// Combinational 4-bit ALU slice. Arithmetic ops compute A + f(B) + c_in so the
// carry can be chained across slices; logic ops force carry to 0.
module alu (
    output logic [3:0] R,
    output logic       zero,
    output logic       carry,
    output logic       sign,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       c_in,
    input  logic [2:0] Op
);

    logic [3:0] b_eff;
    logic [4:0] sum;

    always_comb begin
        b_eff = B;
        unique case (Op[1:0])
            2'b00: b_eff = B;
            2'b01: b_eff = ~B;
            2'b10: b_eff = 4'h0;
            2'b11: b_eff = 4'hF;
            default: b_eff = B;
        endcase
        sum = {1'b0, A} + {1'b0, b_eff} + {4'b0000, c_in};
    end

    always_comb begin
        R     = sum[3:0];
        carry = sum[4];
        if (Op[2]) begin
            carry = 1'b0;
            unique case (Op[1:0])
                2'b00: R = A & B;
                2'b01: R = A | B;
                2'b10: R = A ^ B;
                2'b11: R = ~A;
                default: R = A & B;
            endcase
        end
        zero = (R == 4'h0);
        sign = R[3];
    end

endmodule

// File: rtl/alu_nibble_seq.sv
// Multi-cycle wide-word sequencer: runs the 4-bit ALU once per nibble, LSB first,
// chaining the carry, and registers the wide result and flags for the done cycle.
module alu_nibble_seq
    import alu_nibble_seq_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   A_w,
    input  logic [4*NIBBLES-1:0]   B_w,
    input  logic [2:0]             Op,
    input  logic                   c_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   R_w,
    output logic                   zero,
    output logic                   carry,
    output logic                   sign
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = cnt_width(NIBBLES);
    localparam logic [CW-1:0] LastCnt = CW'(NIBBLES - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
    logic [2:0]     op_q, op_d;
    logic           cin_q, cin_d, chain_q, chain_d;
    logic           zero_q, zero_d, carry_q, carry_d, sign_q, sign_d;

    logic [3:0]     a_nib, b_nib, alu_r;
    logic [W-1:0]   r_ins;
    logic           alu_carry, alu_zero, alu_sign;
    logic           unused_alu;

    assign unused_alu = alu_zero ^ alu_sign;

    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (cnt_q == CW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    alu u_alu (
        .R     (alu_r),
        .zero  (alu_zero),
        .carry (alu_carry),
        .sign  (alu_sign),
        .A     (a_nib),
        .B     (b_nib),
        .c_in  (chain_q),
        .Op    (op_q)
    );

    // Result word with the current slice's nibble merged in
    always_comb begin
        r_ins = r_q;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (cnt_q == CW'(i)) begin
                r_ins[4*i +: 4] = alu_r;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LastCnt) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cin_d   = cin_q;
        chain_d = chain_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        sign_d  = sign_q;
        if (state_q == ST_IDLE && start) begin
            a_d     = A_w;
            b_d     = B_w;
            op_d    = Op;
            cin_d   = c_in;
            chain_d = c_in;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            r_d     = r_ins;
            // Logic slices always restart from the latched carry-in
            chain_d = op_q[2] ? cin_q : alu_carry;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LastCnt) begin
                cnt_d   = cnt_q;
                zero_d  = (r_ins == '0);
                sign_d  = r_ins[W-1];
                carry_d = op_q[2] ? 1'b0 : alu_carry;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cin_q   <= 1'b0;
            chain_q <= 1'b0;
            cnt_q   <= '0;
            r_q     <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cin_q   <= cin_d;
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            sign_q  <= sign_d;
        end
    end

    assign R_w   = r_q;
    assign zero  = zero_q;
    assign carry = carry_q;
    assign sign  = sign_q;

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Multi-cycle wide-word sequencer built around the existing 4-bit ALU.
- Latches two NIBBLES*4-bit operands, feeds them to one internal 4-bit ALU instance one nibble per cycle (LSB first), and chains the ALU carry between nibbles.
- Collects the result nibbles into a wide result register and derives wide zero/carry/sign flags.
- Upstream and downstream of the ALU: drives its A/B/c_in/Op inputs and consumes its R/carry outputs. Gives the datapath 8/16/32-bit arithmetic from the 4-bit unit.

Parameters:
NIBBLES, 4, number of 4-bit slices per word (word width W = 4*NIBBLES); legal range 1..8.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
A_w  input  W  operand A, latched on accepted start
B_w  input  W  operand B, latched on accepted start
Op  input  3  ALU operation code, latched on accepted start; Op[2]=0 arithmetic, Op[2]=1 logic
c_in  input  1  carry-in for nibble 0, latched on accepted start
busy  output  1  high while a word operation is in progress
done  output  1  one-cycle pulse when R_w and the flags become valid
R_w  output  W  wide result, held until the next accepted start
zero  output  1  1 when R_w == 0
carry  output  1  final carry-out (arithmetic ops only)
sign  output  1  R_w[W-1]

Behaviour:
- Reset (asynchronous, active-high, clk-independent):
  - state=IDLE; busy=0, done=0, R_w=0, zero=0, carry=0, sign=0.
  - Nibble counter=0; operand registers=0.
  - Reset asserted mid-operation aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches A_w, B_w, Op and c_in, clears the counter, sets the chain carry to c_in, and goes to RUN.
  - busy=1 from the next cycle.
- RUN (exactly NIBBLES cycles):
  - In cycle k the ALU receives A[4k+3:4k], B[4k+3:4k], the latched Op, and chain-carry c_in.
  - At the edge, ALU R is written to R_w[4k+3:4k].
  - If Op[2]=0, the ALU carry is written to the chain carry.
  - If Op[2]=1, the chain carry is reloaded with the latched c_in, so logic slices never see a propagated carry.
  - The counter increments each cycle; after k=NIBBLES-1 the block goes to DONE.
- DONE (1 cycle):
  - done=1, busy=0; next state is IDLE.
  - Flags are registered so they are valid in the same cycle as done:
    - zero = (R_w==0)
    - sign = R_w[W-1]
    - carry = final chain carry if Op[2]=0, else 0
- Latency: start edge -> done high in cycle NIBBLES+1 after the start edge.
- Throughput: one operation per NIBBLES+2 cycles.
- start while busy or in DONE is ignored (no queueing); the latched operands are unaffected.
- Operand inputs may change freely after the accepted start.
- R_w and flags hold their values from DONE until the next accepted start.
- R_w may show partial nibbles during RUN; it is only valid when done=1 or after it.
- NIBBLES=1: RUN lasts one cycle; behaviour equals a registered 4-bit ALU plus handshake.

Decomposition:
- Shared package/include:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Op constants OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b100, OP_OR=3'b101.
  - Counter width function (clog2 of NIBBLES, min 1).
- One sub-module, the existing alu (4-bit; ports R, zero, carry, sign, A, B, c_in, Op), instantiated once. Its zero and sign outputs are unused.
- Operand nibble select: indexed part-select by counter. No separate module.

Test Plan:
- NIBBLES=4, reset, start with A_w=0x1234, B_w=0x0FCC, Op=OP_ADD, c_in=0 -> busy high 4 cycles; done pulses in cycle 5 after start; R_w=0x2200, carry=0, zero=0, sign=0.
- A_w=0xFFFF, B_w=0x0001, Op=OP_ADD, c_in=0 -> carry ripples across all slices; R_w=0x0000, carry=1, zero=1, sign=0.
- A_w=0x7000, B_w=0x1000, OP_ADD -> R_w=0x8000, sign=1, carry=0. Then A_w=0xF0F0, B_w=0x0FF0, Op=OP_AND, c_in=1 -> R_w=0x00F0, carry=0, zero=0.
- Start held high continuously with operands changed every cycle during RUN -> only the first operands are used, one done per NIBBLES+2 cycles, and results match those operands.
- Assert reset asynchronously (between edges) during RUN cycle 2 -> busy, done, R_w and flags go to 0 immediately; no done follows. A new start after reset gives a correct fresh result.
- NIBBLES=1, A_w=0x9, B_w=0x8, OP_ADD, c_in=1 -> done in cycle 2; R_w=0x2, carry=1, sign=0.
